// File: rtl/bht_pkg.sv
// Shared types and constants for the BHT update controller.
package bht_pkg;

  localparam int unsigned BHT_N_DEF          = 2;
  localparam int unsigned BHT_TABLE_SIZE_DEF = 512;

  function automatic int unsigned table_bits(input int unsigned size);
    return $clog2(size);
  endfunction

  function automatic int unsigned cnt_max(input int unsigned n);
    return (1 << n) - 1;
  endfunction

  localparam int unsigned BHT_CNT_MIN = 0;
  localparam int unsigned BHT_CNT_MAX = cnt_max(BHT_N_DEF);

  // Index width follows the default table size; a different BHT_TABLE_SIZE
  // needs BHT_TABLE_SIZE_DEF changed to match.
  localparam int unsigned BHT_IDX_W = table_bits(BHT_TABLE_SIZE_DEF);

  typedef struct packed {
    logic [BHT_IDX_W-1:0] index;
    logic                 taken;
  } bht_upd_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bht_state_e;

endpackage

// File: rtl/bht_update_fifo.sv
// Power-of-two FIFO of pending branch updates with a synchronous clear.
module bht_update_fifo
  import bht_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  bht_upd_t din,
  output bht_upd_t dout,
  output logic     empty,
  output logic     full
);

  localparam int unsigned PW = $clog2(DEPTH);

  bht_upd_t       mem_q [DEPTH];
  logic [PW:0]    wptr_q, wptr_d;
  logic [PW:0]    rptr_q, rptr_d;
  logic           do_push, do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    do_push = push & ~full & ~clr;
    do_pop  = pop & ~empty & ~clr;
    dout    = mem_q[rptr_q[PW-1:0]];
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT counter write-port owner: clear sweep after reset/flush, then pipelined
// saturating-counter RMW of queued EX updates. Stats ports: BHT_CTRL_STATS_EN.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter  int unsigned BHT_N          = BHT_N_DEF,
  parameter  int unsigned BHT_TABLE_SIZE = BHT_TABLE_SIZE_DEF,
  parameter  int unsigned QUEUE_DEPTH    = 4,
  localparam int unsigned TABLE_BITS     = table_bits(BHT_TABLE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_req,
  output logic                  busy,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_taken,
  output logic                  tbl_rd_en,
  output logic [TABLE_BITS-1:0] tbl_rd_addr,
  input  logic [BHT_N-1:0]      tbl_rd_data,
  output logic                  tbl_wr_en,
  output logic [TABLE_BITS-1:0] tbl_wr_addr,
  output logic [BHT_N-1:0]      tbl_wr_data
`ifdef BHT_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_saturated
`endif
);

  localparam logic [BHT_N-1:0]      CNT_MAX  = BHT_N'(cnt_max(BHT_N));
  localparam logic [BHT_N-1:0]      CNT_MIN  = BHT_N'(BHT_CNT_MIN);
  localparam logic [TABLE_BITS-1:0] IDX_LAST = TABLE_BITS'(BHT_TABLE_SIZE - 1);

  bht_state_e            state_q, state_d;
  logic [TABLE_BITS-1:0] idx_q, idx_d;

  logic                  w_vld_q, w_vld_d;
  bht_upd_t              w_upd_q, w_upd_d;

  logic                  fwd_vld_q, fwd_vld_d;
  logic [TABLE_BITS-1:0] fwd_idx_q, fwd_idx_d;
  logic [BHT_N-1:0]      fwd_data_q, fwd_data_d;

  logic                  q_push, q_pop, q_empty, q_full;
  bht_upd_t              q_din, q_head;

  logic [BHT_N-1:0]      base, cnt_new;
  logic                  w_wr;

  logic                  unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[31:TABLE_BITS+2], upd_pc[1:0]};

  always_comb begin
    q_din.index = upd_pc[TABLE_BITS+1:2];
    q_din.taken = upd_taken;
  end

  bht_update_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush_req),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

  // Sweep FSM; a flush restarts from index 0 regardless of state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush_req) begin
      state_d = ST_CLEAR;
      idx_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_LAST) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    busy      = (state_q == ST_CLEAR);
    upd_ready = ~q_full & ~flush_req;
    q_push    = upd_valid & upd_ready;

    // R stage
    q_pop       = (state_q == ST_RUN) & ~q_empty & ~flush_req;
    tbl_rd_en   = q_pop;
    tbl_rd_addr = q_head.index;
    w_vld_d     = q_pop;
    w_upd_d     = q_pop ? q_head : w_upd_q;

    // W stage: the RAM has not yet seen last cycle's write to the same index
    base = tbl_rd_data;
    if (fwd_vld_q && (fwd_idx_q == w_upd_q.index)) base = fwd_data_q;
    cnt_new = base;
    if (w_upd_q.taken && (base != CNT_MAX))       cnt_new = base + 1'b1;
    else if (!w_upd_q.taken && (base != CNT_MIN)) cnt_new = base - 1'b1;

    w_wr       = w_vld_q & ~flush_req;
    fwd_vld_d  = w_wr;
    fwd_idx_d  = w_upd_q.index;
    fwd_data_d = cnt_new;

    if (state_q == ST_CLEAR) begin
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = idx_q;
      tbl_wr_data = '0;
    end else begin
      tbl_wr_en   = w_wr;
      tbl_wr_addr = w_upd_q.index;
      tbl_wr_data = cnt_new;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_vld_q    <= 1'b0;
      w_upd_q    <= '0;
      fwd_vld_q  <= 1'b0;
      fwd_idx_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      w_vld_q    <= w_vld_d;
      w_upd_q    <= w_upd_d;
      fwd_vld_q  <= fwd_vld_d;
      fwd_idx_q  <= fwd_idx_d;
      fwd_data_q <= fwd_data_d;
    end
  end

`ifdef BHT_CTRL_STATS_EN
  logic [31:0] stat_upd_q, stat_upd_d;
  logic [31:0] stat_sat_q, stat_sat_d;

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_sat_d = stat_sat_q;
    if (w_wr) begin
      stat_upd_d = stat_upd_q + 32'd1;
      if (cnt_new == base) stat_sat_d = stat_sat_q + 32'd1;
    end
    stat_updates   = stat_upd_q;
    stat_saturated = stat_sat_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_upd_q <= '0;
      stat_sat_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_sat_q <= stat_sat_d;
    end
  end
`endif

endmodule

// File: doc/bht_update_ctrl.md
# bht_update_ctrl

Sequencer that owns the write port of the branch history table's counter RAM. It buffers branch-resolution updates from EX in a small queue and performs a pipelined read-modify-write of the saturating counters, with forwarding for back-to-back updates to the same index. It also runs a one-entry-per-cycle clear sweep after reset and on a flush request. It sits between the EX stage and the table storage; the ID-stage query path does not pass through this block.

## Interface
- BHT_N, 2, counter width in bits
- BHT_TABLE_SIZE, 512, number of table entries (power of two)
- QUEUE_DEPTH, 4, update queue depth (power of two, ≥2)

- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- flush_req  in  1  start or restart the clear sweep; discards queued and in-flight updates
- busy  out  1  clear sweep in progress
- upd_valid  in  1  EX branch update request
- upd_ready  out  1  update accepted when valid&ready
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  branch outcome (1 = taken)
- tbl_rd_en  out  1  table read request
- tbl_rd_addr  out  TABLE_BITS  read index
- tbl_rd_data  in  BHT_N  read data, valid the cycle after tbl_rd_en (synchronous read-before-write RAM)
- tbl_wr_en  out  1  table write strobe
- tbl_wr_addr  out  TABLE_BITS  write index
- tbl_wr_data  out  BHT_N  write data

## Operation
- TABLE_BITS = $clog2(BHT_TABLE_SIZE).
- Index = upd_pc[TABLE_BITS+1:2]. The queue stores {index, taken} only.
- States:
  - CLEAR: sweep index idx from 0 to SIZE-1; each cycle write 0 to idx. After writing SIZE-1, go to RUN.
  - RUN: service the queue.
- flush_req in either state:
  - Next state is CLEAR with idx = 0 (restarts a sweep already in progress).
  - Empties the queue.
  - Kills the W stage; no W-stage write occurs in the flush cycle.
- upd_ready = ~queue_full & ~flush_req. Enqueue is allowed in both states.
- R stage (RUN only):
  - Condition: queue not empty and ~flush_req.
  - Pop the head, assert tbl_rd_en with tbl_rd_addr = head index.
  - Register {index, taken} into the W stage.
- W stage:
  - Base value is tbl_rd_data. Exception: if the previous cycle's W-stage write was valid and targeted the same index, use that registered write value (forwarding).
  - new = base+1 if taken and base ≠ all-ones.
  - new = base−1 if not taken and base ≠ 0.
  - Otherwise new = base.
  - Always write new.
- Write port mux: CLEAR drives {1, idx, 0}; RUN drives the W stage. The two never overlap, because a flush kills the W stage.
- busy = (state == CLEAR).

## Timing
- Reset (rstn low) values:
  - state = CLEAR, idx = 0, busy = 1.
  - tbl_wr_en = 1, tbl_wr_addr = 0, tbl_wr_data = 0.
  - tbl_rd_en = 0, upd_ready = 1.
  - Queue empty, W stage invalid, forwarding register invalid.
- Clear sweep: exactly BHT_TABLE_SIZE write cycles after reset release or after the flush cycle. busy drops the cycle after index SIZE-1 is written.
- Update latency, with an empty queue in RUN:
  - Accept at cycle t.
  - Read issued at t+1.
  - Write at t+2.
- Throughput: one update per cycle sustained.
- Queue full: upd_ready = 0. A push and a pop in the same cycle while full is not a push; no bypass.
- Same-index back-to-back updates produce correct sequential counts via forwarding. Non-adjacent repeats are handled by the RAM's read-before-write ordering (the earlier write has completed before the later read).
- Updates accepted during CLEAR wait until RUN; the first pop occurs in the first RUN cycle.

## Configuration
- BHT_CTRL_STATS_EN:
  - When defined, adds outputs stat_updates[31:0] and stat_saturated[31:0].
  - stat_updates counts W-stage writes.
  - stat_saturated counts W-stage writes where new == base.
  - Both counters reset to 0 on rstn and wrap at 2^32. flush_req does not clear them.
  - When undefined, the ports and logic are absent.

## Structure
- Package bht_pkg:
  - Function for TABLE_BITS.
  - Typedef bht_upd_t {index, taken}.
  - Counter saturation max/min constants.
- Sub-module bht_update_fifo: synchronous FIFO of bht_upd_t, with QUEUE_DEPTH and a synchronous clear input driven by flush_req.
- Both the sweep FSM and the RMW pipeline live in bht_update_ctrl.

## Test plan
- Reset release: 512 consecutive cycles with tbl_wr_en = 1, addr 0..511, data 0; busy = 1 throughout, then 0; tbl_rd_en stays 0.
- In RUN, four back-to-back taken updates to pc 0x100 (index 0x40), RAM model initially 0 → writes 1, 2, 3, 3 on consecutive cycles (exercises forwarding and saturation).
- Not-taken update at index 5 holding 0 → write 0; taken at index 6 holding 3 → write 3; with STATS, stat_saturated = 2.
- During the sweep, 5 updates presented → 4 accepted, 5th sees upd_ready = 0. After busy falls, 4 reads issue on consecutive cycles, each followed one cycle later by its write.
- flush_req in RUN with 3 queued and 1 in the W stage → no W-stage write that cycle; queue empties; sweep restarts at idx 0 for 512 cycles; none of the 4 updates are ever written.
- flush_req at idx 200 during CLEAR → next write is idx 0; busy stays high for 512 more cycles.
